tx_byte_buffer: RTL and testbench

- Sits directly downstream of the transmit-side data mux (Tx_Data / Tx_Data_valid) and directly upstream of the UART transmitter.
- Absorbs back-to-back bytes, e.g. the two halves of a 16-bit ALU result, in a small FIFO.
- Releases the bytes one at a time to the UART using a valid-pulse / busy handshake, so no byte is lost while the UART is serialising.

---
 rtl/tx_byte_buffer.sv | 150 +++++++++++++++
 tb/tb_tx_byte_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_byte_buffer.sv
// tx_byte_buffer: small byte FIFO between the transmit data mux and the UART
// transmitter. Bytes written with Tx_Data_valid are queued. A three-state read
// FSM releases them one at a time using a valid-pulse / busy handshake.
// Optional feature macro: TXBUF_ALMOST_FULL_EN adds a registered Almost_full
// output (count >= DEPTH - AF_MARGIN).
//
// Handshake: UART_Data_valid is a single-cycle start pulse, registered
// together with UART_Data. After the pulse the FSM waits for UART_busy to
// rise (WAIT_BUSY) and then fall (WAIT_DONE) before it may issue the next
// pulse. UART_busy is ignored while IDLE. UART_Data holds its value until the
// next pop.
module tx_byte_buffer #(
  parameter int width     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] Tx_Data,
  input  logic             Tx_Data_valid,
  input  logic             UART_busy,
  output logic [width-1:0] UART_Data,
  output logic             UART_Data_valid,
  output logic             Fifo_full,
  output logic             Fifo_empty,
`ifdef TXBUF_ALMOST_FULL_EN
  output logic             Almost_full,
`endif
  output logic             Overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] uart_data_q, uart_data_d;
  logic             uart_valid_q, uart_valid_d;
  logic             overflow_q, overflow_d;
  logic [width-1:0] mem_q [DEPTH];
  logic             full, empty, wr_en, pop;

  // Fullness is judged on the registered (pre-edge) count only, so a pop in
  // the same cycle never rescues a write into a full FIFO.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Read FSM: pop in IDLE, then track one UART frame via busy rise and fall.
  always_comb begin
    state_d      = state_q;
    uart_valid_d = 1'b0;
    uart_data_d  = uart_data_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          uart_data_d  = mem_q[rd_ptr_q];
          uart_valid_d = 1'b1;
          state_d      = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (UART_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!UART_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_en      = Tx_Data_valid && !full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    if (Tx_Data_valid && full) overflow_d = 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers, cleared asynchronously on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      uart_data_q  <= '0;
      uart_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      uart_data_q  <= uart_data_d;
      uart_valid_q <= uart_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= Tx_Data;
  end

  assign UART_Data       = uart_data_q;
  assign UART_Data_valid = uart_valid_q;
  assign Fifo_full       = full;
  assign Fifo_empty      = empty;
  assign Overflow        = overflow_q;

`ifdef TXBUF_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  logic almost_full_q, almost_full_d;

  // Almost-full follows the next count so it updates on the same edge.
  always_comb almost_full_d = (count_d >= AF_LEVEL);

  // Almost-full register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) almost_full_q <= 1'b0;
    else      almost_full_q <= almost_full_d;
  end

  assign Almost_full = almost_full_q;
`else
  logic [31:0] unused_af_margin;
  assign unused_af_margin = AF_MARGIN;
`endif

endmodule

// File: tb/tb_tx_byte_buffer.sv
// Testbench for tx_byte_buffer: directed scenarios plus randomized traffic,
// checked against a transaction-level model (queue of accepted bytes, sticky
// overflow flag, and which phase of a UART frame the buffer is in).
module tb_tx_byte_buffer;

  localparam int W         = 8;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;

  // ---------------- clock / reset / DUT ----------------
  logic         CLK;
  logic         RST;
  logic [W-1:0] Tx_Data;
  logic         Tx_Data_valid;
  logic         UART_busy;
  logic [W-1:0] UART_Data;
  logic         UART_Data_valid;
  logic         Fifo_full;
  logic         Fifo_empty;
  logic         Overflow;
`ifdef TXBUF_ALMOST_FULL_EN
  logic         Almost_full;
`endif

  tx_byte_buffer #(.width(W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Tx_Data        (Tx_Data),
    .Tx_Data_valid  (Tx_Data_valid),
    .UART_busy      (UART_busy),
    .UART_Data      (UART_Data),
    .UART_Data_valid(UART_Data_valid),
    .Fifo_full      (Fifo_full),
    .Fifo_empty     (Fifo_empty),
`ifdef TXBUF_ALMOST_FULL_EN
    .Almost_full    (Almost_full),
`endif
    .Overflow       (Overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];   // bytes accepted and not yet handed to the UART
  logic [W-1:0] got_q[$];   // bytes actually pulsed out by the DUT
  int           phase;      // 0 free, 1 pulse sent / busy not seen, 2 busy seen
  logic         m_ovf;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_pops;
  int           pulses;

  // UART stand-in: after each start pulse, busy low for cfg_delay cycles,
  // then high for cfg_len cycles. busy_hold forces busy high otherwise.
  int   u_delay, u_hold, cfg_delay, cfg_len;
  logic busy_hold;

  function automatic void model_reset();
    exp_q.delete();
    phase   = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endfunction

  // One clock edge of the transaction model, using pre-edge inputs.
  function automatic void model_edge(input logic wr, input logic [W-1:0] d, input logic busy);
    int pre;
    pre     = exp_q.size();
    m_valid = 1'b0;
    if (phase == 0 && pre > 0) begin
      m_valid = 1'b1;
      m_data  = exp_q.pop_front();
      m_pops++;
      phase   = 1;
    end else if (phase == 1 && busy) begin
      phase = 2;
    end else if (phase == 2 && !busy) begin
      phase = 0;
    end
    if (wr) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else              exp_q.push_back(d);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic wr, input logic [W-1:0] d);
    @(negedge CLK);
    Tx_Data_valid = wr;
    Tx_Data       = d;
    if (u_delay > 0) begin
      u_delay--;
      UART_busy = 1'b0;
    end else if (u_hold > 0) begin
      u_hold--;
      UART_busy = 1'b1;
    end else begin
      UART_busy = busy_hold;
    end
    @(posedge CLK);
    model_edge(wr, d, UART_busy);
    #1;
    if (UART_Data_valid === 1'b1) begin
      pulses++;
      got_q.push_back(UART_Data);
      u_delay = cfg_delay;
      u_hold  = cfg_len;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST           = 1'b0;
    Tx_Data_valid = 1'b0;
    Tx_Data       = '0;
    busy_hold     = 1'b0;
    UART_busy     = 1'b0;
    u_delay       = 0;
    u_hold        = 0;
    cfg_delay     = 0;
    cfg_len       = 10;
    model_reset();
    m_pops = 0;
    pulses = 0;
    got_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (UART_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", UART_Data); end
    checks++; if (UART_Data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", UART_Data_valid); end
    checks++; if (Fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", Fifo_empty); end
    checks++; if (Fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", Fifo_full); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", Overflow); end
`ifdef TXBUF_ALMOST_FULL_EN
    checks++; if (Almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b exp 0", Almost_full); end
`endif
  endtask

  task automatic test_single_byte();
    do_reset();
    cfg_delay = 0;
    cfg_len   = 10;
    tick(1'b1, 8'hA5);
    checks++; if (UART_Data_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b exp 0", UART_Data_valid); end
    checks++; if (Fifo_empty !== 1'b0) begin errors++; $display("FAIL single_not_empty: got %b exp 0", Fifo_empty); end
    tick(1'b0, 8'h00);
    checks++; if (UART_Data_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", UART_Data_valid); end
    checks++; if (UART_Data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", UART_Data); end
    checks++; if (Fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b exp 1", Fifo_empty); end
    for (int c = 0; c < 15; c++) begin
      tick(1'b0, 8'h00);
      checks++; if (UART_Data_valid !== 1'b0) begin errors++; $display("FAIL single_extra_pulse: got %b exp 0 cycle %0d", UART_Data_valid, c); end
      checks++; if (UART_Data !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h exp a5 cycle %0d", UART_Data, c); end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulse_count: got %0d exp 1", pulses); end
  endtask

  task automatic test_burst();
    do_reset();
    cfg_delay = 0;
    cfg_len   = 10;
    tick(1'b1, 8'h12);
    tick(1'b1, 8'h34);
    checks++; if (UART_Data_valid !== 1'b1 || UART_Data !== 8'h12) begin errors++; $display("FAIL burst_first: got %b/%h exp 1/12", UART_Data_valid, UART_Data); end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 8'h00);
      checks++; if (UART_Data_valid !== m_valid) begin errors++; $display("FAIL burst_valid: got %b exp %b cycle %0d", UART_Data_valid, m_valid, c); end
      checks++; if (UART_Data !== m_data) begin errors++; $display("FAIL burst_data: got %h exp %h cycle %0d", UART_Data, m_data, c); end
    end
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL burst_count: got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 8'h12 || got_q[1] !== 8'h34) begin errors++; $display("FAIL burst_order: got %h %h exp 12 34", got_q[0], got_q[1]); end
    end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow: got %b exp 0", Overflow); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    cfg_delay = 0;
    cfg_len   = 40;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, W'(i));
      checks++; if (Overflow !== m_ovf) begin errors++; $display("FAIL fill_overflow_step: got %b exp %b write %0d", Overflow, m_ovf, i); end
      checks++; if (Fifo_full !== (exp_q.size() == DEPTH)) begin errors++; $display("FAIL fill_full_step: got %b exp %b write %0d", Fifo_full, exp_q.size() == DEPTH, i); end
    end
    checks++; if (Fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", Fifo_full); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b exp 1", Overflow); end
    cfg_len = 3;
    for (int c = 0; c < 200 && !(exp_q.size() == 0 && phase == 0); c++) begin
      tick(1'b0, 8'h00);
      checks++; if (UART_Data_valid !== m_valid) begin errors++; $display("FAIL fill_valid: got %b exp %b cycle %0d", UART_Data_valid, m_valid, c); end
      checks++; if (UART_Data !== m_data) begin errors++; $display("FAIL fill_data: got %h exp %h cycle %0d", UART_Data, m_data, c); end
    end
    checks++; if (got_q.size() !== 9) begin errors++; $display("FAIL fill_count: got %0d exp 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== W'(i + 1)) begin errors++; $display("FAIL fill_order: got %h exp %h index %0d", got_q[i], W'(i + 1), i); end
    end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL fill_sticky: got %b exp 1", Overflow); end
    checks++; if (Fifo_empty !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b exp 1", Fifo_empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    cfg_len = 3;
    for (int i = 0; i < 20; i++) begin
      cfg_delay = $urandom_range(0, 2);
      tick(1'b1, W'(i));
      checks++; if (UART_Data_valid !== m_valid) begin errors++; $display("FAIL wrap_valid_wr: got %b exp %b byte %0d", UART_Data_valid, m_valid, i); end
      repeat ($urandom_range(7, 10)) begin
        tick(1'b0, 8'h00);
        checks++; if (UART_Data_valid !== m_valid) begin errors++; $display("FAIL wrap_valid: got %b exp %b byte %0d", UART_Data_valid, m_valid, i); end
        checks++; if (UART_Data !== m_data) begin errors++; $display("FAIL wrap_data: got %h exp %h byte %0d", UART_Data, m_data, i); end
      end
    end
    for (int c = 0; c < 100 && !(exp_q.size() == 0 && phase == 0); c++) tick(1'b0, 8'h00);
    checks++; if (got_q.size() !== 20) begin errors++; $display("FAIL wrap_count: got %0d exp 20", got_q.size()); end
    for (int i = 0; i < 20 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== W'(i)) begin errors++; $display("FAIL wrap_order: got %h exp %h index %0d", got_q[i], W'(i), i); end
    end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b exp 0", Overflow); end
  endtask

  task automatic test_full_pop_write();
    do_reset();
    cfg_delay = 0;
    cfg_len   = 20;
    for (int i = 1; i <= 9; i++) tick(1'b1, W'(i));
    checks++; if (Fifo_full !== 1'b1) begin errors++; $display("FAIL fpw_full: got %b exp 1", Fifo_full); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fpw_no_overflow: got %b exp 0", Overflow); end
    for (int c = 0; c < 60 && phase != 0; c++) begin
      tick(1'b0, 8'h00);
      checks++; if (UART_Data_valid !== m_valid) begin errors++; $display("FAIL fpw_wait_valid: got %b exp %b cycle %0d", UART_Data_valid, m_valid, c); end
    end
    tick(1'b1, 8'hEE);
    checks++; if (UART_Data_valid !== 1'b1 || UART_Data !== 8'h02) begin errors++; $display("FAIL fpw_pop: got %b/%h exp 1/02", UART_Data_valid, UART_Data); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL fpw_overflow: got %b exp 1", Overflow); end
    checks++; if (Fifo_full !== 1'b0) begin errors++; $display("FAIL fpw_not_full: got %b exp 0", Fifo_full); end
    cfg_len = 3;
    for (int c = 0; c < 200 && !(exp_q.size() == 0 && phase == 0); c++) begin
      tick(1'b0, 8'h00);
      checks++; if (UART_Data !== m_data) begin errors++; $display("FAIL fpw_data: got %h exp %h cycle %0d", UART_Data, m_data, c); end
    end
    checks++; if (got_q.size() !== 9) begin errors++; $display("FAIL fpw_count: got %0d exp 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== W'(i + 1)) begin errors++; $display("FAIL fpw_order: got %h exp %h index %0d", got_q[i], W'(i + 1), i); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_delay = 0;
    cfg_len   = 14;
    for (int i = 1; i <= 10; i++) tick(1'b1, W'(i));
    for (int c = 0; c < 20 && phase != 2; c++) tick(1'b0, 8'h00);
    checks++; if (Overflow !== 1'b1 || UART_Data !== 8'h01) begin errors++; $display("FAIL mid_pre: got %b/%h exp 1/01", Overflow, UART_Data); end
    @(negedge CLK);
    Tx_Data_valid = 1'b0;
    busy_hold     = 1'b1;
    UART_busy     = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    checks++; if (UART_Data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h exp 00", UART_Data); end
    checks++; if (UART_Data_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", UART_Data_valid); end
    checks++; if (Fifo_empty !== 1'b1 || Fifo_full !== 1'b0) begin errors++; $display("FAIL mid_flags: got empty %b full %b exp 1 0", Fifo_empty, Fifo_full); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b exp 0", Overflow); end
    @(negedge CLK);
    RST = 1'b1;
    got_q.delete();
    tick(1'b1, 8'h5A);
    checks++; if (UART_Data_valid !== 1'b0) begin errors++; $display("FAIL mid_early: got %b exp 0", UART_Data_valid); end
    tick(1'b0, 8'h00);
    checks++; if (UART_Data_valid !== 1'b1 || UART_Data !== 8'h5A) begin errors++; $display("FAIL mid_new_byte: got %b/%h exp 1/5a", UART_Data_valid, UART_Data); end
    busy_hold = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 8'h00);
      checks++; if (UART_Data_valid !== m_valid) begin errors++; $display("FAIL mid_valid_after: got %b exp %b cycle %0d", UART_Data_valid, m_valid, c); end
    end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_random();
    logic         wr;
    logic [W-1:0] d;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      cfg_delay = $urandom_range(0, 2);
      cfg_len   = $urandom_range(1, 6);
      wr        = ($urandom_range(0, 99) < 35);
      d         = W'($urandom_range(0, 255));
      tick(wr, d);
      checks++; if (UART_Data_valid !== m_valid) begin errors++; $display("FAIL rand_valid: got %b exp %b cycle %0d", UART_Data_valid, m_valid, c); end
      checks++; if (UART_Data !== m_data) begin errors++; $display("FAIL rand_data: got %h exp %h cycle %0d", UART_Data, m_data, c); end
      checks++; if (Fifo_full !== (exp_q.size() == DEPTH) || Fifo_empty !== (exp_q.size() == 0)) begin errors++; $display("FAIL rand_flags: got full %b empty %b exp size %0d", Fifo_full, Fifo_empty, exp_q.size()); end
      checks++; if (Overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow: got %b exp %b cycle %0d", Overflow, m_ovf, c); end
    end
    for (int c = 0; c < 300 && !(exp_q.size() == 0 && phase == 0 && u_hold == 0); c++) tick(1'b0, 8'h00);
    checks++; if (pulses !== m_pops) begin errors++; $display("FAIL rand_pulses: got %0d exp %0d", pulses, m_pops); end
  endtask

`ifdef TXBUF_ALMOST_FULL_EN
  task automatic test_almost_full();
    do_reset();
    cfg_delay = 0;
    cfg_len   = 30;
    tick(1'b1, 8'hF0);
    tick(1'b0, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, W'(i));
      checks++; if (Almost_full !== (i >= DEPTH - AF_MARGIN)) begin errors++; $display("FAIL af_rise: got %b exp %b write %0d", Almost_full, i >= DEPTH - AF_MARGIN, i); end
    end
    cfg_len = 3;
    for (int c = 0; c < 200 && !(exp_q.size() == 0 && phase == 0); c++) begin
      tick(1'b0, 8'h00);
      checks++; if (Almost_full !== (exp_q.size() >= DEPTH - AF_MARGIN)) begin errors++; $display("FAIL af_track: got %b exp size %0d", Almost_full, exp_q.size()); end
    end
    checks++; if (Almost_full !== 1'b0) begin errors++; $display("FAIL af_final: got %b exp 0", Almost_full); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    RST           = 1'b0;
    Tx_Data       = '0;
    Tx_Data_valid = 1'b0;
    UART_busy     = 1'b0;
    busy_hold     = 1'b0;
    u_delay       = 0;
    u_hold        = 0;
    cfg_delay     = 0;
    cfg_len       = 10;
    m_pops        = 0;
    pulses        = 0;
    model_reset();
    test_reset();
    test_single_byte();
    test_burst();
    test_fill_overflow();
    test_wrap();
    test_full_pop_write();
    test_reset_mid();
    test_random();
`ifdef TXBUF_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
